hazard_ctrl: RTL and testbench

Stall/flush scheduler for the five-stage LEGv8 pipelined CPU. It sits beside the inter-stage registers and the forwarding units, and sequences the pipeline through hazards the forwarding paths cannot cover:
- load-use on ALU operands;
- load-to-CBZ, which is resolved in ID;
- taken branches resolved in ID.

It drives write-enables for PC and IF/ID, a flush for IF/ID, and a bubble into ID/EX. It also keeps saturating stall and flush event counters for performance analysis.

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the five-stage LEGv8 pipeline: load-use, load-to-CBZ
// and taken-branch handling, plus saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned XZR   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rn_id,
    input  logic [REG_W-1:0] Rm_id,
    input  logic             use_rn_id,
    input  logic             use_rm_id,
    input  logic             cbz_id,
    input  logic             BrTaken_id,
    input  logic             MemtoReg_ex,
    input  logic             RegWrite_ex,
    input  logic [REG_W-1:0] Rd_ex,
    input  logic             MemtoReg_mem,
    input  logic [REG_W-1:0] Rd_mem,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [REG_W-1:0] ZR = REG_W'(XZR);

    typedef enum logic {
        RUN,
        HOLD
    } state_t;

    state_t state, state_next;
    logic   load_ex;
    logic   lu, cz_ex, cz_mem;
    logic   stall, flush;

    assign load_ex = MemtoReg_ex & RegWrite_ex & (Rd_ex != ZR);
    assign lu      = load_ex & ((use_rn_id & (Rn_id == Rd_ex)) |
                                (use_rm_id & (Rm_id == Rd_ex)));
    assign cz_ex   = cbz_id & load_ex & (Rm_id == Rd_ex);
    assign cz_mem  = cbz_id & MemtoReg_mem & (Rd_mem != ZR) & (Rm_id == Rd_mem);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        flush      = 1'b0;
        unique case (state)
            HOLD: begin
                stall      = 1'b1;
                state_next = RUN;
            end
            default: begin
                if (cz_ex) begin
                    stall      = 1'b1;
                    state_next = HOLD;
                end else if (lu || cz_mem) begin
                    stall = 1'b1;
                end else if (BrTaken_id) begin
                    flush = 1'b1;
                end
            end
        endcase
    end

    // Reset overrides the Mealy outputs so the pipeline registers stay frozen as NOPs.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = flush;
        id_ex_bubble = 1'b0;
        if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end
    end

    assign busy = (state == HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// stimulus against a cycle-level behavioural model; a CNT_W=3 copy checks saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Rn_id, Rm_id, Rd_ex, Rd_mem;
    logic       use_rn_id, use_rm_id, cbz_id, BrTaken_id;
    logic       MemtoReg_ex, RegWrite_ex, MemtoReg_mem;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, busy;
    logic [31:0] stall_count, flush_count;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_busy;
    logic [2:0]  s_stall_count, s_flush_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // model: forced stall cycles still owed, and event totals since reset
    int unsigned pend = 0;
    int unsigned scnt = 0;
    int unsigned fcnt = 0;

    logic [4:0] obs, expv;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .CNT_W(32), .XZR(31)) dut (
        .clk(clk), .reset(reset), .Rn_id(Rn_id), .Rm_id(Rm_id),
        .use_rn_id(use_rn_id), .use_rm_id(use_rm_id), .cbz_id(cbz_id),
        .BrTaken_id(BrTaken_id), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .Rd_ex(Rd_ex), .MemtoReg_mem(MemtoReg_mem), .Rd_mem(Rd_mem),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .busy(busy),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.REG_W(5), .CNT_W(3), .XZR(31)) dut_small (
        .clk(clk), .reset(reset), .Rn_id(Rn_id), .Rm_id(Rm_id),
        .use_rn_id(use_rn_id), .use_rm_id(use_rm_id), .cbz_id(cbz_id),
        .BrTaken_id(BrTaken_id), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .Rd_ex(Rd_ex), .MemtoReg_mem(MemtoReg_mem), .Rd_mem(Rd_mem),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .busy(s_busy),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    function automatic logic [2:0] sat3(input int unsigned v);
        return (v > 7) ? 3'd7 : v[2:0];
    endfunction

    function automatic bit load_cbz_in_ex();
        return cbz_id && MemtoReg_ex && RegWrite_ex && Rd_ex != 5'd31 && Rm_id == Rd_ex;
    endfunction

    // 0 normal, 1 stall, 2 flush, 3 reset
    function automatic int action();
        bit ld_hit, mem_hit;
        if (!reset) return 3;
        if (pend > 0) return 1;
        ld_hit = MemtoReg_ex && RegWrite_ex && Rd_ex != 5'd31 &&
                 ((use_rn_id && Rn_id == Rd_ex) || (use_rm_id && Rm_id == Rd_ex));
        mem_hit = cbz_id && MemtoReg_mem && Rd_mem != 5'd31 && Rm_id == Rd_mem;
        if (load_cbz_in_ex() || ld_hit || mem_hit) return 1;
        if (BrTaken_id) return 2;
        return 0;
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy}
    function automatic logic [4:0] model_out();
        logic b;
        b = (reset && pend > 0);
        case (action())
            1:       return {4'b0001, b};
            2:       return 5'b11100;
            3:       return 5'b00110;
            default: return 5'b11000;
        endcase
    endfunction

    task automatic tick();
        int  a;
        bit  czx;
        a   = action();
        czx = (pend == 0) && load_cbz_in_ex();
        @(posedge clk);
        if (!reset) begin
            pend = 0; scnt = 0; fcnt = 0;
        end else begin
            if (a == 1) scnt++;
            if (a == 2) fcnt++;
            if (pend > 0) pend--;
            else if (czx) pend = 1;
        end
        #1;
    endtask

    task automatic set_idle();
        Rn_id = 5'd0; Rm_id = 5'd0; Rd_ex = 5'd0; Rd_mem = 5'd0;
        use_rn_id = 1'b0; use_rm_id = 1'b0; cbz_id = 1'b0; BrTaken_id = 1'b0;
        MemtoReg_ex = 1'b0; RegWrite_ex = 1'b0; MemtoReg_mem = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        #1 reset = 1'b0;
        pend = 0; scnt = 0; fcnt = 0;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00110) begin bad++; $display("FAIL reset_pattern got=%b want=00110", obs); end
        total++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        tick();
        tick();
        reset = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11000) begin bad++; $display("FAIL post_reset got=%b want=11000", obs); end
    endtask

    task automatic test_load_use();
        int unsigned s0;
        s0 = scnt;
        Rd_ex = 5'd1; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; Rn_id = 5'd1; use_rn_id = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00010) begin bad++; $display("FAIL lu_stall got=%b want=00010", obs); end
        tick();
        set_idle();
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11000) begin bad++; $display("FAIL lu_after got=%b want=11000", obs); end
        total++;
        if (stall_count !== s0 + 1) begin bad++; $display("FAIL lu_count got=%0d want=%0d", stall_count, s0 + 1); end
    endtask

    task automatic test_cbz_hold();
        int unsigned s0, f0;
        s0 = scnt; f0 = fcnt;
        cbz_id = 1'b1; Rm_id = 5'd2; Rd_ex = 5'd2; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1;
        BrTaken_id = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00010) begin bad++; $display("FAIL cbz_run_stall got=%b want=00010", obs); end
        tick();
        MemtoReg_ex = 1'b0; RegWrite_ex = 1'b0; Rd_ex = 5'd0;
        MemtoReg_mem = 1'b1; Rd_mem = 5'd2;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00011) begin bad++; $display("FAIL cbz_hold got=%b want=00011", obs); end
        tick();
        MemtoReg_mem = 1'b0; BrTaken_id = 1'b0;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11000) begin bad++; $display("FAIL cbz_release got=%b want=11000", obs); end
        total++;
        if (stall_count !== s0 + 2 || flush_count !== f0) begin
            bad++; $display("FAIL cbz_counts got=%0d/%0d want=%0d/%0d", stall_count, flush_count, s0 + 2, f0);
        end
        set_idle();
    endtask

    task automatic test_xzr();
        int unsigned s0;
        s0 = scnt;
        Rd_ex = 5'd31; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; Rn_id = 5'd31; use_rn_id = 1'b1;
        cbz_id = 1'b1; Rm_id = 5'd31; MemtoReg_mem = 1'b1; Rd_mem = 5'd31;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11000) begin bad++; $display("FAIL xzr_no_stall got=%b want=11000", obs); end
        tick();
        total++;
        if (stall_count !== s0) begin bad++; $display("FAIL xzr_count got=%0d want=%0d", stall_count, s0); end
        set_idle();
    endtask

    task automatic test_flush();
        int unsigned s0, f0;
        s0 = scnt; f0 = fcnt;
        BrTaken_id = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11100) begin bad++; $display("FAIL flush got=%b want=11100", obs); end
        tick();
        total++;
        if (flush_count !== f0 + 1) begin bad++; $display("FAIL flush_count got=%0d want=%0d", flush_count, f0 + 1); end
        Rd_ex = 5'd4; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; Rm_id = 5'd4; use_rm_id = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00010) begin bad++; $display("FAIL flush_vs_lu got=%b want=00010", obs); end
        tick();
        total++;
        if (flush_count !== f0 + 1 || stall_count !== s0 + 1) begin
            bad++; $display("FAIL flush_vs_lu_count got=%0d/%0d want=%0d/%0d", stall_count, flush_count, s0 + 1, f0 + 1);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        cbz_id = 1'b1; Rm_id = 5'd3; Rd_ex = 5'd3; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1;
        tick();
        set_idle();
        tick();
        Rd_ex = 5'd5; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; Rn_id = 5'd5; use_rn_id = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00010) begin bad++; $display("FAIL b2b_stall got=%b want=00010", obs); end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_hold();
        cbz_id = 1'b1; Rm_id = 5'd6; Rd_ex = 5'd6; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1;
        tick();
        set_idle();
        #1;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL hold_entry busy=%b want=1", busy); end
        #1 reset = 1'b0;
        pend = 0; scnt = 0; fcnt = 0;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b00110) begin bad++; $display("FAIL mid_hold_reset got=%b want=00110", obs); end
        total++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0 || s_stall_count !== 3'd0) begin
            bad++; $display("FAIL mid_hold_counters got=%0d/%0d want=0/0", stall_count, flush_count);
        end
        tick();
        reset = 1'b1;
        #1;
        obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
        total++;
        if (obs !== 5'b11000) begin bad++; $display("FAIL mid_hold_release got=%b want=11000", obs); end
    endtask

    task automatic test_saturation();
        Rd_ex = 5'd7; MemtoReg_ex = 1'b1; RegWrite_ex = 1'b1; Rn_id = 5'd7; use_rn_id = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (s_stall_count !== sat3(scnt) || stall_count !== scnt) begin
                bad++;
                $display("FAIL saturation got=%0d/%0d want=%0d/%0d", s_stall_count, stall_count, sat3(scnt), scnt);
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [4:0] pick [4];
        pick[0] = 5'd1; pick[1] = 5'd2; pick[2] = 5'd3; pick[3] = 5'd31;
        for (int i = 0; i < 400; i++) begin
            Rn_id = pick[$urandom_range(3)]; Rm_id = pick[$urandom_range(3)];
            Rd_ex = pick[$urandom_range(3)]; Rd_mem = pick[$urandom_range(3)];
            use_rn_id = 1'($urandom); use_rm_id = 1'($urandom); cbz_id = 1'($urandom);
            BrTaken_id = 1'($urandom); MemtoReg_ex = 1'($urandom); RegWrite_ex = 1'($urandom);
            MemtoReg_mem = 1'($urandom);
            #1;
            obs  = {pc_write, if_id_write, if_id_flush, id_ex_bubble, busy};
            expv = model_out();
            total++;
            if (obs !== expv) begin bad++; $display("FAIL rand_out cyc=%0d got=%b want=%b", i, obs, expv); end
            tick();
            total++;
            if (stall_count !== scnt || flush_count !== fcnt ||
                s_stall_count !== sat3(scnt) || s_flush_count !== sat3(fcnt)) begin
                bad++;
                $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d", i,
                         stall_count, flush_count, s_stall_count, s_flush_count,
                         scnt, fcnt, sat3(scnt), sat3(fcnt));
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_cbz_hold();
        test_xzr();
        test_flush();
        test_back_to_back();
        test_reset_mid_hold();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
